// File: rtl/imem_loader_if.sv
// Stream-in / byte-write-out bundle for the instruction memory loader.
// master = program source plus memory observer, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into a byte-wide imem, MSB byte first,
// holding the CPU until the program (plus an optional zero halt word) is written.
//
// state    | meaning
// ACCEPT   | waiting for the next program word, in_ready=1
// WRITE    | emitting the latched word, one byte per cycle
// PAD      | emitting the 0x00000000 halt word after the last word
// DONE     | program resident, CPU released, new words flag overflow
module imem_loader #(
  parameter int ADDR_W   = 6,
  parameter bit PAD_HALT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          i_load_start,
  output logic          o_cpu_hold,
  output logic          o_load_done,
  output logic          o_overflow
);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_WRITE  = 2'd1,
    S_PAD    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [1:0]        r_byte_idx;
  logic [1:0]        w_byte_idx_nxt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;

  logic              w_in_ready;
  logic              w_handshake;
  logic              w_last_byte;
  logic              w_addr_wrap;
  logic [7:0]        w_word_byte;

  assign w_in_ready  = (r_state == S_ACCEPT);
  assign w_handshake = bus.in_valid & w_in_ready;
  assign w_last_byte = (r_byte_idx == 2'd3);
  // Writing the top byte address means the increment wraps: memory is full.
  assign w_addr_wrap = (r_addr == ADDR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_byte_idx <= 2'd0;
      r_word     <= 32'h0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word     <= w_word_nxt;
      r_last     <= w_last_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_byte_idx_nxt = r_byte_idx;
    w_word_nxt     = r_word;
    w_last_nxt     = r_last;
    w_overflow_nxt = r_overflow;

    case (r_state)
      S_ACCEPT: begin
        if (w_handshake) begin
          w_word_nxt     = bus.in_data;
          w_last_nxt     = bus.in_last;
          w_byte_idx_nxt = 2'd0;
          w_state_nxt    = S_WRITE;
        end
      end

      S_WRITE: begin
        w_addr_nxt     = r_addr + ADDR_ONE;
        w_byte_idx_nxt = r_byte_idx + 2'd1;
        if (w_last_byte) begin
          if (w_addr_wrap) begin
            w_state_nxt = S_DONE;
          end else if (r_last && PAD_HALT) begin
            w_state_nxt = S_PAD;
          end else if (r_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACCEPT;
          end
        end
      end

      S_PAD: begin
        w_addr_nxt     = r_addr + ADDR_ONE;
        w_byte_idx_nxt = r_byte_idx + 2'd1;
        if (w_last_byte) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Restart takes priority over a simultaneously offered word.
        if (i_load_start) begin
          w_state_nxt    = S_ACCEPT;
          w_addr_nxt     = '0;
          w_byte_idx_nxt = 2'd0;
          w_overflow_nxt = 1'b0;
        end else if (bus.in_valid) begin
          w_overflow_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_ACCEPT;
      end
    endcase
  end

  always_comb begin
    w_word_byte = 8'h00;
    case (r_byte_idx)
      2'd0:    w_word_byte = r_word[31:24];
      2'd1:    w_word_byte = r_word[23:16];
      2'd2:    w_word_byte = r_word[15:8];
      default: w_word_byte = r_word[7:0];
    endcase
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = (r_state == S_WRITE) || (r_state == S_PAD);
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = (r_state == S_WRITE) ? w_word_byte : 8'h00;

  assign o_cpu_hold  = (r_state != S_DONE);
  assign o_load_done = (r_state == S_DONE);
  assign o_overflow  = r_overflow;

endmodule
